// File: rtl/ethernet_header_encoder.sv
// ---------------------------------------------------------------------------
// ethernet_header_encoder
//
// Transmit-side counterpart of the Ethernet header decoder. One header
// (dMac, sMac, oTag, eType) is taken per frame, followed by a 64-bit payload
// stream. The output is a 64-bit word stream:
//   word0 = {sMac[15:0], dMac[47:0]}
//   word1 = {eType, oTag, sMac[47:16]}
//   word2.. = payload words
// Each word carries a per-frame index (counter) that saturates at
// 2^CNT_W-1, matching the decoder's word counter.
//
// Handshakes (all three interfaces): a transfer happens on a rising clk edge
// where valid && ready are both high. valid is never made to wait on ready;
// ready may depend on valid only through the downstream output stage.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   hdrValid / hdrReady / dMac / sMac / oTag / eType   header input
//   plValid / plReady / plData / plLast                payload input
//   dataOut / outValid / outReady / outLast / counter  output stream
//   state_dbg  current FSM state (0 IDLE, 1 HDR1, 2 PAY)
// ---------------------------------------------------------------------------
module ethernet_header_encoder #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdrValid,
  output logic             hdrReady,
  input  logic [47:0]      dMac,
  input  logic [47:0]      sMac,
  input  logic [15:0]      oTag,
  input  logic [15:0]      eType,
  input  logic             plValid,
  output logic             plReady,
  input  logic [63:0]      plData,
  input  logic             plLast,
  output logic [63:0]      dataOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             outLast,
  output logic [CNT_W-1:0] counter,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR1 = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Only the header bits needed for word1 have to outlive the handshake;
  // word0 is built straight from the inputs in the handshake cycle.
  logic [31:0] smac_hi_q;
  logic [15:0] otag_q;
  logic [15:0] etype_q;

  logic             ld;
  logic             load;
  logic [63:0]      load_data;
  logic             load_last;
  logic [CNT_W-1:0] load_cnt;
  logic             hdr_take;
  logic [CNT_W-1:0] cnt_inc;

  // The output register may take a new word whenever it is empty or its
  // current word is being consumed this cycle.
  assign ld = !outValid || outReady;

  assign cnt_inc = (counter == {CNT_W{1'b1}}) ? counter : counter + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    hdrReady  = 1'b0;
    plReady   = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    load_cnt  = '0;
    hdr_take  = 1'b0;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered then.
        hdrReady = ld && rst;
        if (hdrValid && ld) begin
          hdr_take  = 1'b1;
          load      = 1'b1;
          load_data = {sMac[15:0], dMac};
          load_cnt  = '0;
          state_nxt = HDR1;
        end
      end
      HDR1: begin
        if (ld) begin
          load      = 1'b1;
          load_data = {etype_q, otag_q, smac_hi_q};
          load_cnt  = CNT_W'(1);
          state_nxt = PAY;
        end
      end
      PAY: begin
        plReady = ld;
        if (plValid && ld) begin
          load      = 1'b1;
          load_data = plData;
          load_last = plLast;
          load_cnt  = cnt_inc;
          if (plLast) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      smac_hi_q <= '0;
      otag_q    <= '0;
      etype_q   <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_take) begin
        smac_hi_q <= sMac[47:16];
        otag_q    <= oTag;
        etype_q   <= eType;
      end
    end
  end

  // Output stage. When ld is high but nothing loads, only outValid drops;
  // data, last and counter keep their previous values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataOut  <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
      counter  <= '0;
    end else if (ld) begin
      outValid <= load;
      if (load) begin
        dataOut <= load_data;
        outLast <= load_last;
        counter <= load_cnt;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ethernet_header_encoder.sv
module tb_ethernet_header_encoder;

  localparam int CNT_W = 7;
  localparam int EW    = 1 + CNT_W + 64;   // {last, cnt, data}
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hdrValid = 1'b0;
  logic             hdrReady;
  logic [47:0]      dMac = '0;
  logic [47:0]      sMac = '0;
  logic [15:0]      oTag = '0;
  logic [15:0]      eType = '0;
  logic             plValid = 1'b0;
  logic             plReady;
  logic [63:0]      plData = '0;
  logic             plLast = 1'b0;
  logic [63:0]      dataOut;
  logic             outValid;
  logic             outReady = 1'b1;
  logic             outLast;
  logic [CNT_W-1:0] counter;
  logic [1:0]       state_dbg;

  ethernet_header_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .hdrValid(hdrValid), .hdrReady(hdrReady),
    .dMac(dMac), .sMac(sMac), .oTag(oTag), .eType(eType),
    .plValid(plValid), .plReady(plReady), .plData(plData), .plLast(plLast),
    .dataOut(dataOut), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .counter(counter), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int or_mode = 0;   // 0: outReady=1, 1: random, 2: driven by a test

  logic [EW-1:0] exp_q[$];
  logic [63:0]   data_log[$];
  int            pop_cyc[$];

  // ---------------- reference model ----------------
  // Header words per the wire format; index k of a frame with n payload words.
  function automatic logic [63:0] hdr_word(input int k, input logic [47:0] dm,
      input logic [47:0] sm, input logic [15:0] ot, input logic [15:0] et);
    logic [63:0] w;
    if (k == 0) w = {sm[15:0], dm};
    else        w = {et, ot, sm[47:16]};
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] idx_of(input int k);
    int v;
    v = (k > CMAX) ? CMAX : k;
    return v[CNT_W-1:0];
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            prev_stall = 1'b0;
  logic [EW-1:0] prev_word;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (!rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!outValid || {outLast, counter, dataOut} !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", outValid,
                   {outLast, counter, dataOut}, prev_word);
        end
      end
      if (outValid && !outReady) begin
        checks++;
        if (hdrReady || plReady) begin
          errors++;
          $display("FAIL stall_ready: got hdrReady=%0b plReady=%0b expected 0 0", hdrReady, plReady);
        end
      end
      if (outValid && outReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %0h expected no word", dataOut);
        end else begin
          e = exp_q.pop_front();
          if ({outLast, counter, dataOut} !== e) begin
            errors++;
            $display("FAIL word: got last=%0b cnt=%0d data=%0h expected last=%0b cnt=%0d data=%0h",
                     outLast, counter, dataOut, e[EW-1], e[EW-2 -: CNT_W], e[63:0]);
          end
        end
        data_log.push_back(dataOut);
        pop_cyc.push_back(cyc);
      end
      prev_stall = outValid && !outReady;
      prev_word  = {outLast, counter, dataOut};
    end
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 0) outReady = 1'b1;
    else if (or_mode == 1) outReady = ($urandom_range(0, 3) != 0);
  end

  // ---------------- drivers ----------------
  task automatic wait_hs(input bit is_hdr, input string name);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (is_hdr ? hdrReady : plReady) break;
      t++;
      if (t > 2000) begin
        errors++; checks++;
        $display("FAIL %s_timeout: got no handshake expected one within 2000 cycles", name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] dm, input logic [47:0] sm,
      input logic [15:0] ot, input logic [15:0] et, input int n, input bit gaps);
    logic [63:0] pl[$];
    for (int i = 0; i < n; i++) pl.push_back({$urandom, $urandom});
    exp_q.push_back({1'b0, idx_of(0), hdr_word(0, dm, sm, ot, et)});
    exp_q.push_back({1'b0, idx_of(1), hdr_word(1, dm, sm, ot, et)});
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), idx_of(i + 2), pl[i]});
    dMac = dm; sMac = sm; oTag = ot; eType = et; hdrValid = 1'b1;
    wait_hs(1'b1, "hdr");
    hdrValid = 1'b0;
    // Scrambled afterwards: the DUT must have sampled at the handshake.
    dMac = {$urandom, $urandom}; sMac = {$urandom, $urandom};
    oTag = 16'($urandom); eType = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        plValid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      plData = pl[i]; plLast = (i == n - 1); plValid = 1'b1;
      wait_hs(1'b0, "pl");
      plValid = 1'b0;
      plData = {$urandom, $urandom};
      plLast = $urandom_range(0, 1);
    end
  endtask

  task automatic send_rand(input int n, input bit gaps);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom), n, gaps);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [47:0] dm0;
    logic [47:0] sm0;
    // Pin the model's header packing with hand-computed words.
    check("model_w0", hdr_word(0, 48'h0A0B0C0D0E0F, 48'h112233445566, 16'h8100, 16'h0800),
          64'h55660A0B0C0D0E0F);
    check("model_w1", hdr_word(1, 48'h0A0B0C0D0E0F, 48'h112233445566, 16'h8100, 16'h0800),
          64'h0800810011223344);
    check("model_sat", idx_of(200), CMAX);

    // Values during reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outValid", outValid, 0);
    check("rst_hdrReady", hdrReady, 0);
    check("rst_plReady", plReady, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: reset mid-frame, word0 stuck under backpressure.
    or_mode = 2; outReady = 1'b0;
    dMac = 48'h1; sMac = 48'h2; oTag = 16'h3; eType = 16'h4; hdrValid = 1'b1;
    wait_hs(1'b1, "rst_hdr");
    hdrValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_outValid", outValid, 1);
    rst = 1'b0;
    #1;
    check("arst_outValid", outValid, 0);
    check("arst_counter", counter, 0);
    check("arst_state", state_dbg, 0);
    check("arst_dataOut", dataOut, 0);
    check("arst_hdrReady", hdrReady, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; outReady = 1'b1; or_mode = 0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("idle_hdrReady", hdrReady, 1);

    // Test 2: single directed frame, then decode it back.
    data_log.delete();
    send_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h8100, 16'h0800, 2, 1'b0);
    drain("single");
    check("single_count", data_log.size(), 4);
    if (data_log.size() >= 2) begin
      check("single_w0", data_log[0], 64'h55660A0B0C0D0E0F);
      check("single_w1", data_log[1], 64'h0800810011223344);
      dm0 = data_log[0][47:0];
      sm0 = {data_log[1][31:0], data_log[0][63:48]};
      check("dec_dmac", dm0, 48'h0A0B0C0D0E0F);
      check("dec_smac", sm0, 48'h112233445566);
      check("dec_otag", data_log[1][47:32], 16'h8100);
      check("dec_etype", data_log[1][63:48], 16'h0800);
    end

    // Test 3: backpressure for 3 cycles while word1 is on the output.
    or_mode = 2; outReady = 1'b1;
    fork
      send_rand(3, 1'b0);
      begin
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!(outValid && counter == 0) && t < 100);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_word1_cnt", counter, 1);
          check("bp_plReady", plReady, 0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    drain("bp");
    or_mode = 0;

    // Test 4: back-to-back one-word frames, full rate.
    pop_cyc.delete();
    send_rand(1, 1'b0);
    send_rand(1, 1'b0);
    drain("b2b");
    check("b2b_count", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6)
      check("b2b_span", pop_cyc[5] - pop_cyc[0], 5);

    // Test 5: payload gaps and random backpressure.
    or_mode = 1;
    for (int f = 0; f < 12; f++) send_rand($urandom_range(1, 6), 1'b1);
    drain("rand");

    // Test 6: counter saturation with a long frame.
    data_log.delete();
    send_rand(CMAX + 3, 1'b0);
    drain("sat");
    or_mode = 0;

    // Reset recovery is covered above; one more frame after all that.
    send_rand(2, 1'b1);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
